// File: rtl/result_unloader_pkg.sv
// Shared widths, FSM state encoding and frame-length helper for the result unloader.
package mat_pkg;

    localparam int ELEM_W = 16;
    localparam int MAX_N  = 4;
    localparam int BYTE_W = 8;
    localparam int RES_W  = ELEM_W * MAX_N * MAX_N;
    localparam int CNT_W  = 6;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Bytes in a frame of an n x n result: two bytes per entry.
    function automatic logic [CNT_W-1:0] frame_bytes(input logic [2:0] n);
        logic [CNT_W-1:0] nw;
        nw = {3'b000, n};
        return CNT_W'(nw * nw * 2);
    endfunction

    function automatic logic size_legal(input logic [2:0] n);
        return (n == 3'd2) || (n == 3'd3) || (n == 3'd4);
    endfunction

endpackage

// File: rtl/result_unloader_if.sv
// Result capture inputs and byte-stream handshake of the result unloader.
interface result_unloader_if;
    import mat_pkg::*;

    logic [RES_W-1:0]  res_mat;
    logic [2:0]        mat_size;
    logic              res_valid;
    logic [BYTE_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;
    logic              dout_last;

    modport master (
        input  res_mat, mat_size, res_valid, dout_ready,
        output dout, dout_valid, dout_last
    );

    modport slave (
        output res_mat, mat_size, res_valid, dout_ready,
        input  dout, dout_valid, dout_last
    );

endinterface

// File: rtl/result_unloader_byte_mux.sv
// Selects byte k of an n x n result held in the shadow register; entry 0 sits in the top slot.
module result_byte_mux
    import mat_pkg::*;
(
    input  logic [RES_W-1:0]  shadow,
    input  logic [2:0]        n,
    input  logic [CNT_W-1:0]  k,
    output logic [BYTE_W-1:0] byte_out
);

    logic [4:0]        nn;
    logic [4:0]        entry_idx;
    logic [3:0]        slot;
    logic [ELEM_W-1:0] entry;

    always_comb begin
        nn        = {2'b00, n} * {2'b00, n};
        entry_idx = k[CNT_W-1:1];
        // Entries are packed top-down, so entry e lives in slot nn-1-e counted from bit 0.
        slot      = 4'(nn - 5'd1 - entry_idx);
        entry     = shadow[{slot, 4'b0000} +: ELEM_W];
        byte_out  = k[0] ? entry[BYTE_W-1:0] : entry[ELEM_W-1:BYTE_W];
    end

endmodule

// File: rtl/result_unloader.sv
// Captures a 2x2..4x4 result matrix and streams it high-byte-first, row-major, over a valid/ready byte port.
//
// state | meaning
// IDLE  | waiting for res_valid; illegal sizes only raise size_err
// SEND  | presenting byte k of the latched frame until the last one is accepted
module result_unloader
    import mat_pkg::*;
(
    input  logic               CLK,
    input  logic               RST_N,
    result_unloader_if.master  bus,
    output logic               busy,
    output logic               overrun,
    output logic               size_err
);

    state_t             state;
    state_t             state_nx;
    logic [RES_W-1:0]   shadow;
    logic [2:0]         n_lat;
    logic [CNT_W-1:0]   k;
    logic [CNT_W-1:0]   k_nx;
    logic [CNT_W-1:0]   k_last;
    logic               capture;
    logic               set_ovr;
    logic               set_serr;
    logic               sending;
    logic               is_last;
    logic [BYTE_W-1:0]  mux_byte;

    assign sending = (state == SEND);
    assign k_last  = frame_bytes(n_lat) - CNT_W'(1);
    assign is_last = (k == k_last);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            k        <= '0;
            shadow   <= '0;
            n_lat    <= '0;
            overrun  <= 1'b0;
            size_err <= 1'b0;
        end else begin
            state <= state_nx;
            k     <= k_nx;
            if (capture) begin
                shadow <= bus.res_mat;
                n_lat  <= bus.mat_size;
            end
            if (set_ovr) begin
                overrun <= 1'b1;
            end
            if (set_serr) begin
                size_err <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        k_nx     = k;
        capture  = 1'b0;
        set_ovr  = 1'b0;
        set_serr = 1'b0;
        case (state)
            IDLE: begin
                if (bus.res_valid) begin
                    if (size_legal(bus.mat_size)) begin
                        capture  = 1'b1;
                        k_nx     = '0;
                        state_nx = SEND;
                    end else begin
                        set_serr = 1'b1;
                    end
                end
            end
            SEND: begin
                // A result arriving mid-frame is dropped; the current frame keeps going.
                if (bus.res_valid) begin
                    set_ovr = 1'b1;
                end
                if (bus.dout_ready) begin
                    if (is_last) begin
                        k_nx     = '0;
                        state_nx = IDLE;
                    end else begin
                        k_nx = k + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                k_nx     = '0;
            end
        endcase
    end

    result_byte_mux u_byte_mux (
        .shadow   (shadow),
        .n        (n_lat),
        .k        (k),
        .byte_out (mux_byte)
    );

    assign bus.dout_valid = sending;
    assign bus.dout_last  = sending && is_last;
    assign bus.dout       = sending ? mux_byte : '0;
    assign busy           = sending;

endmodule

// File: tb/tb_result_unloader.sv
// Directed and randomized frames checked against a byte-list model of the result stream.
module tb_result_unloader;
    import mat_pkg::*;

    logic CLK;
    logic RST_N;
    logic busy;
    logic overrun;
    logic size_err;

    int checks;
    int failures;
    bit exp_ovr;
    bit exp_serr;

    result_unloader_if ifc ();

    result_unloader dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .bus      (ifc.master),
        .busy     (busy),
        .overrun  (overrun),
        .size_err (size_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, {31'd0, ifc.dout_valid}, 32'd0);
        chk({tag, "_last"},  {31'd0, ifc.dout_last},  32'd0);
        chk({tag, "_dout"},  {24'd0, ifc.dout},       32'd0);
        chk({tag, "_busy"},  {31'd0, busy},           32'd0);
        chk({tag, "_ovr"},   {31'd0, overrun},        {31'd0, exp_ovr});
        chk({tag, "_serr"},  {31'd0, size_err},       {31'd0, exp_serr});
    endtask

    // mode: 0 always ready, 1 ready pattern 1,0,0 repeating, 2 random ready.
    task automatic run_frame(input int n, input logic [15:0] ents [16], input int mode,
                             input int ovr_at, input int rst_at);
        logic [RES_W-1:0] m;
        logic [15:0]      en;
        logic [7:0]       exp_byte;
        logic             rdy;
        bit               ovr_done;
        int               nn;
        int               len;
        int               idx;
        int               cyc;
        nn = n * n;
        len = 2 * nn;
        idx = 0;
        cyc = 0;
        ovr_done = 0;
        m = '0;
        for (int e = 0; e < nn; e++) m = (m << 16) | RES_W'(ents[e]);
        ifc.res_mat   = m;
        ifc.mat_size  = 3'(n);
        ifc.res_valid = 1'b1;
        ifc.dout_ready = 1'b0;
        step();
        ifc.res_valid = 1'b0;
        while (idx < len && cyc < 400) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            ifc.dout_ready = rdy;
            en = ents[idx / 2];
            exp_byte = (idx % 2 == 0) ? en[15:8] : en[7:0];
            chk("valid", {31'd0, ifc.dout_valid}, 32'd1);
            chk("byte",  {24'd0, ifc.dout},       {24'd0, exp_byte});
            chk("last",  {31'd0, ifc.dout_last},  (idx == len - 1) ? 32'd1 : 32'd0);
            chk("busy",  {31'd0, busy},           32'd1);
            if (idx == rst_at) begin
                #2 RST_N = 1'b0;
                exp_ovr = 0;
                exp_serr = 0;
                #1 chk_idle("async_rst");
                @(negedge CLK);
                RST_N = 1'b1;
                ifc.dout_ready = 1'b0;
                step();
                chk_idle("post_rst");
                return;
            end
            if (idx == ovr_at && !ovr_done) begin
                ovr_done = 1;
                ifc.res_valid = 1'b1;
                ifc.res_mat   = ~m;
                ifc.mat_size  = 3'd2;
                exp_ovr = 1;
            end
            step();
            ifc.res_valid = 1'b0;
            chk("overrun", {31'd0, overrun}, {31'd0, exp_ovr});
            if (rdy) idx++;
            cyc++;
        end
        chk("frame_done", (idx == len) ? 32'd1 : 32'd0, 32'd1);
        ifc.dout_ready = 1'b0;
        chk_idle("end_frame");
    endtask

    logic [15:0] ents [16];
    int          rn;

    initial begin
        checks = 0;
        failures = 0;
        exp_ovr = 0;
        exp_serr = 0;
        RST_N = 1'b0;
        ifc.res_mat = '0;
        ifc.mat_size = 3'd0;
        ifc.res_valid = 1'b0;
        ifc.dout_ready = 1'b0;
        #12;
        chk_idle("reset");
        @(negedge CLK);
        RST_N = 1'b1;
        step();
        chk_idle("idle");

        // 2x2 basic
        for (int i = 0; i < 16; i++) ents[i] = 16'(i + 1);
        run_frame(2, ents, 0, -1, -1);

        // 3x3 ordering
        for (int i = 0; i < 16; i++) ents[i] = 16'((i + 1) * 16'h0101);
        run_frame(3, ents, 0, -1, -1);

        // 4x4 with backpressure
        for (int i = 0; i < 16; i++) ents[i] = 16'hFFEE - 16'(i) * 16'h1111;
        run_frame(4, ents, 1, -1, -1);

        // overrun at byte 5 of a 2x2 frame
        for (int i = 0; i < 16; i++) ents[i] = 16'hA000 + 16'(i * 3);
        run_frame(2, ents, 0, 4, -1);

        // illegal sizes
        ifc.res_mat = '1;
        ifc.mat_size = 3'd5;
        ifc.res_valid = 1'b1;
        step();
        ifc.res_valid = 1'b0;
        exp_serr = 1;
        chk_idle("size5");
        ifc.mat_size = 3'd1;
        ifc.res_valid = 1'b1;
        step();
        ifc.res_valid = 1'b0;
        step();
        chk_idle("size1");

        // reset at byte 10 of a 4x4 frame, then a clean 2x2 frame
        for (int i = 0; i < 16; i++) ents[i] = 16'($urandom);
        run_frame(4, ents, 0, -1, 9);
        for (int i = 0; i < 16; i++) ents[i] = 16'($urandom);
        run_frame(2, ents, 0, -1, -1);

        // randomized frames with random backpressure
        for (int f = 0; f < 8; f++) begin
            rn = int'($urandom_range(2, 4));
            for (int i = 0; i < 16; i++) ents[i] = 16'($urandom);
            run_frame(rn, ents, 2, -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/result_unloader.md
Name: result_unloader

Overview:
- Downstream neighbour of data_loader: captures the 256-bit result matrix (res_mat) when a multiply completes and streams it off-chip as bytes over an 8-bit valid/ready port.
- Turns the wide parallel result into the byte-serial form the pad ring can carry.
- Supports 2x2, 3x3 and 4x4 results; each entry is 16 bits, sent high byte first, row-major.

Parameters:
- ELEM_W, 16, width of one result entry in bits
- MAX_N, 4, largest matrix dimension; result bus width is ELEM_W*MAX_N*MAX_N = 256
- BYTE_W, 8, output byte width

Ports:
- CLK  in  1  system clock; all logic on rising edge
- RST_N  in  1  asynchronous active-low reset
- res_mat  in  256  result matrix from data_loader; N*N entries packed in bits [16*N*N-1:0], entry 0 in the top slot
- mat_size  in  3  matrix dimension N for this result; legal values 2, 3, 4
- res_valid  in  1  one-cycle strobe: res_mat and mat_size are valid this cycle
- dout  out  8  output byte
- dout_valid  out  1  dout holds a valid byte
- dout_ready  in  1  consumer accepts the byte this cycle
- dout_last  out  1  dout is the final byte of the frame; qualified by dout_valid
- busy  out  1  high from the capture edge until the last byte is accepted
- overrun  out  1  sticky; set when res_valid arrives while busy
- size_err  out  1  sticky; set when res_valid arrives with an illegal mat_size

Behaviour:
- Reset (async, RST_N=0) clears the following, and also aborts any frame in progress:
  - dout=0, dout_valid=0, dout_last=0, busy=0, overrun=0, size_err=0
  - state=IDLE, byte counter=0, shadow register=0
- FSM has two states: IDLE and SEND.
- IDLE, res_valid=1 with mat_size in {2,3,4}:
  - copy res_mat into the 256-bit shadow register; latch N; clear byte index k=0; move to SEND.
  - dout_valid, busy and the first byte are all registered on the same edge, so the first byte appears the cycle after res_valid (latency 1).
- IDLE, res_valid=1 with any other mat_size: set size_err, stay in IDLE, capture nothing.
- SEND, byte ordering:
  - byte index k runs from 0 to 2*N*N-1.
  - entry e = k>>1 sits at shadow bits [16*(N*N-e)-1 -: 16].
  - even k outputs the entry's high byte; odd k outputs its low byte.
- SEND, handshake:
  - a transfer happens when dout_valid & dout_ready.
  - without a transfer, dout, dout_valid and dout_last hold stable. No bubbles: the next byte is presented on the edge that accepts the current one.
- dout_last=1 exactly when k = 2*N*N-1.
- Transfer of the last byte: the next edge drives dout_valid=0, dout_last=0, busy=0 and returns to IDLE.
- A new res_valid on that same edge is treated as arriving in IDLE only from the following cycle. Back-to-back results therefore need at least one idle cycle.
- SEND, res_valid=1: set overrun. The new result is dropped and the current frame continues unchanged.
- dout is 0 whenever dout_valid=0.
- Byte counter is 6 bits (maximum 31). Compare against 2*N*N-1 using the latched N.
- Frame lengths: 8 bytes for N=2, 18 for N=3, 32 for N=4.
- Sticky flags clear only on reset.

Decomposition:
- Package mat_pkg holds:
  - ELEM_W, MAX_N, BYTE_W, RES_W=256;
  - typedef state_t {IDLE, SEND};
  - function frame_bytes(n) returning 2*n*n.
- One sub-module, result_byte_mux: a combinational selector that maps (shadow, N, k) to a byte.
- The FSM, counter and handshake stay in result_unloader.

Test Plan:
- 2x2 basic:
  - stimulus: res_mat[63:0]=0x0001_0002_0003_0004, mat_size=2, res_valid pulse, dout_ready=1.
  - response: bytes 00,01,00,02,00,03,00,04 on consecutive cycles starting one cycle after res_valid; dout_last only on 04; busy falls after it.
- 3x3 ordering:
  - stimulus: entries 0x0101..0x0909 in the top-to-bottom slots of [143:0], mat_size=3.
  - response: 18 bytes 01,01,02,02,...,09,09; dout_last on byte 18.
- 4x4 with backpressure:
  - stimulus: res_mat=0xFFEE...(16 distinct entries), dout_ready toggled 1,0,0,1...
  - response: dout and dout_last held stable across stall cycles; 32 bytes in order; no byte duplicated or skipped.
- Overrun:
  - stimulus: second res_valid with different data at byte 5 of a 2x2 frame.
  - response: overrun=1; remaining bytes are still from the first matrix; the second is discarded.
- Illegal size:
  - stimulus: res_valid with mat_size=5.
  - response: size_err=1; dout_valid stays 0; busy stays 0.
- Reset mid-frame:
  - stimulus: RST_N low asynchronously at byte 10 of a 4x4 frame.
  - response: dout_valid/busy/dout drop to 0 immediately. After release, a new 2x2 capture streams correctly from byte 0.
